// File: rtl/sqlite_dpi_pkg.sv
// Command and FSM encodings shared by the row batcher and the SQLite DPI bridge.
package sqlite_dpi_pkg;

   typedef enum logic [1:0] {
      CMD_NOP    = 2'd0,
      CMD_BEGIN  = 2'd1,
      CMD_INSERT = 2'd2,
      CMD_COMMIT = 2'd3
   } sqlite_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BEGIN,
      ST_INSERT,
      ST_COMMIT
   } sqlite_batch_state_e;

endpackage

// File: rtl/sqlite_row_fifo.sv
// Synchronous record FIFO feeding the batcher; head_o shows the oldest record.
module sqlite_row_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push_i,
   input  logic [DATA_W-1:0]       data_i,
   input  logic                    pop_i,
   output logic [DATA_W-1:0]       head_o,
   output logic [$clog2(DEPTH):0]  level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wrPtr_q;
   logic [AW-1:0]     rdPtr_q;
   logic [AW:0]       level_q;

   // Storage carries no reset; only the pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem[wrPtr_q] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         if (push_i) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (pop_i) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         case ({push_i, pop_i})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   assign head_o  = mem[rdPtr_q];
   assign level_o = level_q;

endmodule

// File: rtl/sqlite_row_batcher.sv
// Groups buffered records into BEGIN / INSERT* / COMMIT command batches for the DPI bridge.
// Define SQLITE_BATCH_TIMEOUT_EN to flush partial batches after TIMEOUT idle cycles.
module sqlite_row_batcher
   import sqlite_dpi_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int DEPTH     = 16,
   parameter int BATCH_MAX = 8,
   parameter int TIMEOUT   = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    flush_req,
   output logic                    out_valid,
   input  logic                    out_ready,
   output sqlite_cmd_e             out_op,
   output logic [DATA_W-1:0]       out_data,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    idle,
   output logic [31:0]             batch_cnt
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int RW = $clog2(BATCH_MAX) + 1;

   if (DEPTH < BATCH_MAX || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_badParams
      $error("sqlite_row_batcher: DEPTH must be a power of two >= BATCH_MAX and TIMEOUT >= 1");
   end

   sqlite_batch_state_e state_q;
   sqlite_cmd_e         op_q;
   logic                valid_q;
   logic [RW-1:0]       remaining_q;
   logic [31:0]         batchCnt_q;
   logic                flushPend_q;
   logic                flushPend_d;

   logic                push;
   logic                pop;
   logic [DATA_W-1:0]   head;
   logic [LW-1:0]       fifoLevel;
   logic                haveData;
   logic                fullBatch;
   logic                timeoutHit;
   logic                startBatch;
   logic                commitDone;
   logic [RW-1:0]       batchLen;

   assign in_ready = (fifoLevel < LW'(DEPTH)) && !rst;
   assign push     = in_valid && in_ready;
   assign pop      = (state_q == ST_INSERT) && out_ready;

   sqlite_row_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (in_data),
      .pop_i   (pop),
      .head_o  (head),
      .level_o (fifoLevel)
   );

   assign haveData   = (fifoLevel != '0);
   assign fullBatch  = (fifoLevel >= LW'(BATCH_MAX));
   assign startBatch = (state_q == ST_IDLE) &&
                       (fullBatch || (haveData && (flushPend_q || timeoutHit)));
   assign batchLen   = fullBatch ? RW'(BATCH_MAX) : RW'(fifoLevel);
   assign commitDone = (state_q == ST_COMMIT) && out_ready;

`ifdef SQLITE_BATCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;

   // Only idle cycles with data waiting advance the timer; a batch start rearms it.
   assign timer_d    = (state_q == ST_IDLE && haveData && !startBatch) ? timer_q + 1'b1 : '0;
   assign timeoutHit = (timer_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   assign timeoutHit = 1'b0;
`endif

   // A request arriving in the COMMIT cycle survives the clear and serves the next batch.
   assign flushPend_d = (flushPend_q && !commitDone) || (flush_req && haveData);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= CMD_NOP;
         valid_q     <= 1'b0;
         remaining_q <= '0;
         batchCnt_q  <= '0;
         flushPend_q <= 1'b0;
      end else begin
         flushPend_q <= flushPend_d;
         case (state_q)
            ST_IDLE: begin
               if (startBatch) begin
                  state_q     <= ST_BEGIN;
                  op_q        <= CMD_BEGIN;
                  valid_q     <= 1'b1;
                  remaining_q <= batchLen;
               end
            end
            ST_BEGIN: begin
               if (out_ready) begin
                  state_q <= ST_INSERT;
                  op_q    <= CMD_INSERT;
               end
            end
            ST_INSERT: begin
               if (out_ready) begin
                  remaining_q <= remaining_q - 1'b1;
                  if (remaining_q == RW'(1)) begin
                     state_q <= ST_COMMIT;
                     op_q    <= CMD_COMMIT;
                  end
               end
            end
            ST_COMMIT: begin
               if (out_ready) begin
                  state_q    <= ST_IDLE;
                  op_q       <= CMD_NOP;
                  valid_q    <= 1'b0;
                  batchCnt_q <= batchCnt_q + 32'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               op_q    <= CMD_NOP;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // The FIFO head only moves on an accepted INSERT, so the payload holds while stalled.
   assign out_data  = (op_q == CMD_INSERT) ? head : '0;
   assign out_valid = valid_q;
   assign out_op    = op_q;
   assign level     = fifoLevel;
   assign idle      = (state_q == ST_IDLE) && !haveData;
   assign batch_cnt = batchCnt_q;

endmodule

// File: tb/tb_sqlite_row_batcher.sv
// Randomized and scenario-driven bench for sqlite_row_batcher against a queue-based command model.
// Build with SQLITE_BATCH_TIMEOUT_EN defined to exercise the timeout flush path.
module tb_sqlite_row_batcher;

   localparam int DATA_W    = 64;
   localparam int DEPTH     = 8;
   localparam int BATCH_MAX = 4;
   localparam int TIMEOUT   = 16;

   localparam logic [1:0] OP_NOP    = 2'd0;
   localparam logic [1:0] OP_BEGIN  = 2'd1;
   localparam logic [1:0] OP_INSERT = 2'd2;
   localparam logic [1:0] OP_COMMIT = 2'd3;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              flush_req;
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        out_op;
   logic [DATA_W-1:0] out_data;
   logic [3:0]        level;
   logic              idle;
   logic [31:0]       batch_cnt;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference state: buffered records, the command list of the open batch and bookkeeping.
   logic [DATA_W-1:0] refFifo[$];
   logic [1:0]        refCmds[$];
   bit                refPend;
   logic [31:0]       refBatches;
   int                refTimer;

   always #5 clk = ~clk;

   sqlite_row_batcher #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .BATCH_MAX (BATCH_MAX),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush_req (flush_req),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_op    (out_op),
      .out_data  (out_data),
      .level     (level),
      .idle      (idle),
      .batch_cnt (batch_cnt)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic refReset();
      refFifo.delete();
      refCmds.delete();
      refPend    = 1'b0;
      refBatches = '0;
      refTimer   = 0;
   endtask

   // Compare every DUT output with what the reference predicts for the current cycle.
   task automatic compareAll(input bit rs);
      logic        expValid;
      logic [1:0]  expOp;
      logic [63:0] expData;
      expValid = (refCmds.size() != 0);
      expOp    = expValid ? refCmds[0] : OP_NOP;
      expData  = (expOp == OP_INSERT) ? refFifo[0] : 64'd0;
      checkOutput("out_valid", 64'(out_valid), 64'(expValid));
      checkOutput("out_op",    64'(out_op),    64'(expOp));
      checkOutput("out_data",  out_data,       expData);
      checkOutput("level",     64'(level),     64'(refFifo.size()));
      checkOutput("idle",      64'(idle),      64'(!expValid && refFifo.size() == 0));
      checkOutput("batch_cnt", 64'(batch_cnt), 64'(refBatches));
      checkOutput("in_ready",  64'(in_ready),  64'(!rs && refFifo.size() < DEPTH));
   endtask

   // Advance the reference by one clock using this cycle's inputs.
   task automatic modelStep(input bit v, input logic [63:0] d, input bit f, input bit r, input bit rs);
      int          lvl;
      bit          accept;
      bit          commitSeen;
      bit          timedOut;
      logic [1:0]  op;
      logic [63:0] dropped;
      if (rs) begin
         refReset();
         return;
      end
      lvl        = refFifo.size();
      accept     = v && (lvl < DEPTH);
      commitSeen = 1'b0;
      if (refCmds.size() != 0) begin
         refTimer = 0;
         if (r) begin
            op = refCmds.pop_front();
            if (op == OP_INSERT) begin
               dropped = refFifo.pop_front();
            end
            if (op == OP_COMMIT) begin
               refBatches = refBatches + 32'd1;
               commitSeen = 1'b1;
            end
         end
      end else begin
         timedOut = 1'b0;
`ifdef SQLITE_BATCH_TIMEOUT_EN
         timedOut = (refTimer == TIMEOUT - 1);
`endif
         if (lvl >= BATCH_MAX || (lvl > 0 && (refPend || timedOut))) begin
            refTimer = 0;
            refCmds.push_back(OP_BEGIN);
            for (int k = 0; k < ((lvl < BATCH_MAX) ? lvl : BATCH_MAX); k++) begin
               refCmds.push_back(OP_INSERT);
            end
            refCmds.push_back(OP_COMMIT);
         end else begin
            refTimer = (lvl > 0) ? refTimer + 1 : 0;
         end
      end
      refPend = (refPend && !commitSeen) || (f && lvl > 0);
      if (accept) begin
         refFifo.push_back(d);
      end
   endtask

   // One clock: drive inputs after the falling edge, check, step the model, wait for the next fall.
   task automatic applyStimulus(input bit v, input logic [63:0] d, input bit f, input bit r, input bit rs);
      in_valid  = v;
      in_data   = d;
      flush_req = f;
      out_ready = r;
      rst       = rs;
      #1;
      compareAll(rs);
      modelStep(v, d, f, r, rs);
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n, input bit r);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 64'd0, 1'b0, r, 1'b0);
      end
   endtask

   initial begin
      int accepted;
      int insDone;
      bit rs;
      bit willInsert;
      bit acc;
      bit v;
      int pValid;
      int pReady;

      in_valid  = 1'b0;
      in_data   = '0;
      flush_req = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      refReset();
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
      idleCycles(2, 1'b1);

      // Full batch of four.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 64'hA0 + 64'(i), 1'b0, 1'b1, 1'b0);
      end
      idleCycles(10, 1'b1);

      // Partial batch: flushed by timeout when enabled, otherwise waits for flush_req.
      applyStimulus(1'b1, 64'hB0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 64'hB1, 1'b0, 1'b1, 1'b0);
      idleCycles(200, 1'b1);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
      idleCycles(10, 1'b1);

      // Fill the FIFO while the bridge stalls, then drain.
      accepted = 0;
      for (int c = 0; c < 54; c++) begin
         v   = (accepted < 10);
         acc = v && (refFifo.size() < DEPTH);
         applyStimulus(v, 64'hC0 + 64'(accepted), 1'b0, (c >= 14), 1'b0);
         if (acc) accepted++;
      end
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
      idleCycles(15, 1'b1);

      // Backpressure toggling every cycle.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 64'hF0 + 64'(i), 1'b0, 1'b0, 1'b0);
      end
      for (int c = 0; c < 24; c++) begin
         applyStimulus(1'b0, 64'd0, 1'b0, c[0], 1'b0);
      end

      // Reset after two INSERTs of a four-record batch.
      insDone = 0;
      for (int c = 0; c < 20; c++) begin
         rs         = (insDone == 2);
         willInsert = !rs && refCmds.size() != 0 && refCmds[0] == OP_INSERT;
         applyStimulus(c < 4, 64'hD0 + 64'(c), 1'b0, 1'b1, rs);
         if (rs) insDone = 99;
         else if (willInsert) insDone++;
      end

      // Flush with an empty FIFO, then a flush during a batch with one leftover record.
      idleCycles(3, 1'b1);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
      idleCycles(6, 1'b1);
      for (int c = 0; c < 20; c++) begin
         applyStimulus(c < 5, 64'hE0 + 64'(c), (c == 6), 1'b1, 1'b0);
      end

      // Randomized traffic with changing valid/ready densities.
      for (int blk = 0; blk < 8; blk++) begin
         pValid = $urandom_range(3, 90);
         pReady = $urandom_range(20, 100);
         for (int c = 0; c < 500; c++) begin
            applyStimulus($urandom_range(0, 99) < pValid,
                          {$urandom(), $urandom()},
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 99) < pReady,
                          $urandom_range(0, 399) == 0);
         end
      end
      idleCycles(5, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
